// File: rtl/vx_fetch_ibuffer_pkg.sv
// Shared fetch/ibuffer types and default sizes; no logic.
// Fetch-to-decode payload grouping at the default configuration.
package vx_fetch_ibuffer_pkg;

    localparam int VX_NUM_WARPS   = 4;
    localparam int VX_NUM_THREADS = 4;
    localparam int VX_IBUF_SIZE   = 4;
    localparam int VX_PC_BITS     = 31;
    localparam int VX_UUID_WIDTH  = 44;

    typedef struct packed {
        logic [$clog2(VX_NUM_WARPS)-1:0] wid;
        logic [VX_PC_BITS-1:0]           PC;
        logic [VX_NUM_THREADS-1:0]       tmask;
        logic [31:0]                     instr;
        logic [VX_UUID_WIDTH-1:0]        uuid;
    } fetch_data_t;

endpackage

// File: rtl/vx_fetch_ibuffer_queue.sv
// Single-warp circular FIFO: write visible next cycle, head read is combinational.
// Push ignored when full, pop ignored when empty; no bypass.
module vx_ibuf_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_dat,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rd_ptr];

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vx_fetch_ibuffer.sv
// Per-warp instruction buffer with round-robin issue to decode; 1-cycle push-to-visible.
// in_ready depends only on the target warp's fullness; a stalled grant is locked until it fires.
module vx_fetch_ibuffer
    import vx_fetch_ibuffer_pkg::*;
#(
    parameter int NUM_WARPS   = VX_NUM_WARPS,
    parameter int NUM_THREADS = VX_NUM_THREADS,
    parameter int IBUF_SIZE   = VX_IBUF_SIZE,
    parameter int PC_BITS     = VX_PC_BITS,
    parameter int UUID_WIDTH  = VX_UUID_WIDTH,
    parameter int NW_WIDTH    = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NW_WIDTH-1:0]    in_wid,
    input  logic [PC_BITS-1:0]     in_PC,
    input  logic [NUM_THREADS-1:0] in_tmask,
    input  logic [31:0]            in_instr,
    input  logic [UUID_WIDTH-1:0]  in_uuid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NW_WIDTH-1:0]    out_wid,
    output logic [PC_BITS-1:0]     out_PC,
    output logic [NUM_THREADS-1:0] out_tmask,
    output logic [31:0]            out_instr,
    output logic [UUID_WIDTH-1:0]  out_uuid,
    output logic [NUM_WARPS-1:0]   ibuf_pop,
    output logic [NUM_WARPS-1:0]   ibuf_empty
);

    // The wid is implied by which queue holds the entry, so it is not stored.
    typedef struct packed {
        logic [PC_BITS-1:0]     PC;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            instr;
        logic [UUID_WIDTH-1:0]  uuid;
    } ibuf_ent_t;

    localparam int ENT_W = $bits(ibuf_ent_t);

    ibuf_ent_t             w_in_ent;
    ibuf_ent_t             w_q_dat [NUM_WARPS];
    logic [NUM_WARPS-1:0]  w_full;
    logic [NUM_WARPS-1:0]  w_empty;
    logic [NUM_WARPS-1:0]  w_req;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic [NW_WIDTH-1:0]   w_rr_grant;
    logic [NW_WIDTH-1:0]   w_grant;
    logic [NW_WIDTH-1:0]   w_idx;
    logic                  w_found;

    logic [NW_WIDTH-1:0]   r_prio;
    logic                  r_locked;
    logic [NW_WIDTH-1:0]   r_lock_grant;

    assign w_in_ent   = '{PC: in_PC, tmask: in_tmask, instr: in_instr, uuid: in_uuid};
    assign in_ready   = ~w_full[in_wid];
    assign w_in_fire  = in_valid && in_ready;
    assign w_req      = ~w_empty;
    assign out_valid  = |w_req;
    assign w_out_fire = out_valid && out_ready;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_queue
        vx_ibuf_queue #(
            .DATA_W (ENT_W),
            .DEPTH  (IBUF_SIZE)
        ) u_queue (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_in_fire && (in_wid == NW_WIDTH'(w))),
            .i_dat   (w_in_ent),
            .i_pop   (w_out_fire && (w_grant == NW_WIDTH'(w))),
            .o_dat   (w_q_dat[w]),
            .o_full  (w_full[w]),
            .o_empty (w_empty[w])
        );
    end

    always_comb begin
        w_rr_grant = r_prio;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_idx = r_prio + NW_WIDTH'(i);
            if (!w_found && w_req[w_idx]) begin
                w_rr_grant = w_idx;
                w_found    = 1'b1;
            end
        end
    end

    // A stalled grant stays put even if a higher-priority warp fills meanwhile.
    assign w_grant = r_locked ? r_lock_grant : w_rr_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio       <= '0;
            r_locked     <= 1'b0;
            r_lock_grant <= '0;
        end else begin
            r_locked     <= out_valid && !out_ready;
            r_lock_grant <= w_grant;
            if (w_out_fire) begin
                r_prio <= w_grant + 1'b1;
            end
        end
    end

    assign out_wid    = w_grant;
    assign out_PC     = w_q_dat[w_grant].PC;
    assign out_tmask  = w_q_dat[w_grant].tmask;
    assign out_instr  = w_q_dat[w_grant].instr;
    assign out_uuid   = w_q_dat[w_grant].uuid;
    assign ibuf_pop   = w_out_fire ? (NUM_WARPS'(1) << w_grant) : '0;
    assign ibuf_empty = w_empty;

endmodule

// File: tb/tb_vx_fetch_ibuffer.sv
// Bench for vx_fetch_ibuffer: queue-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_vx_fetch_ibuffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_wid;
    logic [30:0] in_PC;
    logic [3:0]  in_tmask;
    logic [31:0] in_instr;
    logic [43:0] in_uuid;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_wid;
    logic [30:0] out_PC;
    logic [3:0]  out_tmask;
    logic [31:0] out_instr;
    logic [43:0] out_uuid;
    logic [3:0]  ibuf_pop;
    logic [3:0]  ibuf_empty;

    vx_fetch_ibuffer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wid     (in_wid),
        .in_PC      (in_PC),
        .in_tmask   (in_tmask),
        .in_instr   (in_instr),
        .in_uuid    (in_uuid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_wid    (out_wid),
        .out_PC     (out_PC),
        .out_tmask  (out_tmask),
        .out_instr  (out_instr),
        .out_uuid   (out_uuid),
        .ibuf_pop   (ibuf_pop),
        .ibuf_empty (ibuf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one plain queue per warp plus the arbitration rules.
    typedef struct {
        logic [30:0] pc;
        logic [3:0]  tm;
        logic [31:0] ins;
        logic [43:0] uid;
    } ent_t;

    ent_t mq [4][$];
    int   m_prio    = 0;
    bit   m_stalled = 0;
    int   m_last    = 0;

    always @(negedge clk) begin
        int   g;
        bit   v;
        bit   push_ok;
        ent_t e;
        if (reset) begin
            for (int w = 0; w < 4; w++) mq[w].delete();
            m_prio    = 0;
            m_stalled = 0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_empty", 64'(ibuf_empty), 64'hf);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_pop", 64'(ibuf_pop), 64'd0);
        end else begin
            v = 0;
            g = 0;
            for (int w = 0; w < 4; w++) begin
                if (mq[w].size() != 0) v = 1;
                chk("m_empty", 64'(ibuf_empty[w]), 64'(mq[w].size() == 0));
            end
            if (m_stalled) begin
                g = m_last;
            end else begin
                for (int k = 3; k >= 0; k--) begin
                    if (mq[(m_prio + k) % 4].size() != 0) g = (m_prio + k) % 4;
                end
            end
            push_ok = in_valid && (mq[in_wid].size() < 4);
            chk("m_in_ready", 64'(in_ready), 64'(mq[in_wid].size() < 4));
            chk("m_out_valid", 64'(out_valid), 64'(v));
            if (v) begin
                chk("m_out_wid", 64'(out_wid), 64'(g));
                chk("m_out_PC", 64'(out_PC), 64'(mq[g][0].pc));
                chk("m_out_tmask", 64'(out_tmask), 64'(mq[g][0].tm));
                chk("m_out_instr", 64'(out_instr), 64'(mq[g][0].ins));
                chk("m_out_uuid", 64'(out_uuid), 64'(mq[g][0].uid));
                chk("m_pop", 64'(ibuf_pop), out_ready ? (64'd1 << g) : 64'd0);
            end else begin
                chk("m_pop_idle", 64'(ibuf_pop), 64'd0);
            end
            if (push_ok) begin
                e.pc = in_PC; e.tm = in_tmask; e.ins = in_instr; e.uid = in_uuid;
                mq[in_wid].push_back(e);
            end
            if (v && out_ready) begin
                void'(mq[g].pop_front());
                m_prio    = (g + 1) % 4;
                m_stalled = 0;
            end else begin
                m_stalled = v;
                m_last    = g;
            end
        end
    end

    logic [43:0] uid_ctr = 44'd1;

    task automatic step(input logic v, input logic [1:0] w, input logic [30:0] pc, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_wid    = w;
        in_PC     = pc;
        in_tmask  = pc[4:1] ^ {2'b00, w};
        in_instr  = {pc[15:0], 16'hC0DE} ^ {30'd0, w};
        in_uuid   = uid_ctr;
        uid_ctr   = uid_ctr + 44'd1;
        out_ready = ordy;
        #2;
    endtask

    logic [30:0] exp_pc [3];

    initial begin
        reset = 0; in_valid = 0; in_wid = 0; in_PC = 0; in_tmask = 0;
        in_instr = 0; in_uuid = 0; out_ready = 0;
        #1 reset = 1;
        #1;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_empty", 64'(ibuf_empty), 64'hf);
        chk("init_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Reset in the middle of traffic
        for (int i = 0; i < 3; i++) step(1, 2'd1, 31'h10 + 31'(2 * i), 0);
        step(0, 2'd0, 31'h0, 0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_empty", 64'(ibuf_empty), 64'hd);
        reset = 1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_empty", 64'(ibuf_empty), 64'hf);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 reset = 0;
        #1;
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_empty", 64'(ibuf_empty), 64'hf);

        // Per-warp full
        for (int i = 0; i < 4; i++) step(1, 2'd2, 31'h200 + 31'(2 * i), 0);
        step(1, 2'd2, 31'h300, 0);
        chk("full_w2_ready", 64'(in_ready), 64'd0);
        step(1, 2'd0, 31'h400, 0);
        chk("full_w0_ready", 64'(in_ready), 64'd1);
        step(0, 2'd0, 31'h0, 0);
        chk("full_empty", 64'(ibuf_empty), 64'ha);
        repeat (6) step(0, 2'd0, 31'h0, 1);
        chk("full_drained", 64'(ibuf_empty), 64'hf);

        // FIFO ordering within warp 3
        for (int i = 0; i < 3; i++) step(1, 2'd3, 31'h100 + 31'(2 * i), 0);
        exp_pc[0] = 31'h100; exp_pc[1] = 31'h102; exp_pc[2] = 31'h104;
        for (int i = 0; i < 3; i++) begin
            step(0, 2'd0, 31'h0, 1);
            chk("ord_pc", 64'(out_PC), 64'(exp_pc[i]));
            chk("ord_pop", 64'(ibuf_pop), 64'h8);
        end
        step(0, 2'd0, 31'h0, 1);
        chk("ord_done", 64'(out_valid), 64'd0);

        // Round-robin across four loaded warps
        for (int i = 0; i < 8; i++) step(1, 2'(i % 4), 31'h800 + 31'(2 * i), 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 2'd0, 31'h0, 1);
            chk("rr_wid", 64'(out_wid), 64'(i % 4));
            chk("rr_pop", 64'(ibuf_pop), 64'd1 << (i % 4));
        end

        // Grant held while decode stalls, other warp filling
        step(1, 2'd1, 31'h500, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 2'd0, 31'h600 + 31'(2 * i), 0);
            chk("stall_wid", 64'(out_wid), 64'd1);
            chk("stall_pc", 64'(out_PC), 64'h500);
            chk("stall_pop", 64'(ibuf_pop), 64'd0);
        end
        repeat (6) step(0, 2'd0, 31'h0, 1);
        chk("stall_drained", 64'(ibuf_empty), 64'hf);

        // Full queue refuses push even while popping
        for (int i = 0; i < 4; i++) step(1, 2'd0, 31'h700 + 31'(2 * i), 0);
        step(1, 2'd0, 31'h7f0, 1);
        chk("fsp_ready", 64'(in_ready), 64'd0);
        chk("fsp_pop", 64'(ibuf_pop), 64'd1);
        step(0, 2'd0, 31'h0, 0);
        chk("fsp_ready_next", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'd0, 31'h0, 1);
            chk("fsp_left", 64'(out_valid), 64'd1);
        end
        step(0, 2'd0, 31'h0, 1);
        chk("fsp_count3", 64'(out_valid), 64'd0);

        repeat (2) step(0, 2'd0, 31'h0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_fetch_ibuffer.md
# vx_fetch_ibuffer

Per-warp instruction buffer directly downstream of the fetch stage. It accepts icache responses (wid, PC, tmask, instr, uuid) from the fetch output handshake and queues them in one FIFO per warp. A round-robin arbiter selects one non-empty warp per cycle for the decode handshake. On every dequeue it emits a one-hot `ibuf_pop` pulse, which fetch uses to keep its per-warp in-flight count at or below `IBUF_SIZE`.

## Interface
- `NUM_WARPS`, 4, number of warps; power of 2, ≥2
- `NUM_THREADS`, 4, tmask width
- `IBUF_SIZE`, 4, entries per warp queue; power of 2, ≥2
- `PC_BITS`, 31, PC width (PC[0] implicit zero)
- `UUID_WIDTH`, 44, instruction uuid width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `in_valid`  in  1  fetch response valid
- `in_ready`  out  1  buffer can accept `in_wid`
- `in_wid`  in  NW_WIDTH  warp id (NW_WIDTH = clog2(NUM_WARPS))
- `in_PC`  in  PC_BITS  instruction PC
- `in_tmask`  in  NUM_THREADS  thread mask
- `in_instr`  in  32  instruction word
- `in_uuid`  in  UUID_WIDTH  trace uuid
- `out_valid`  out  1  entry presented to decode
- `out_ready`  in  1  decode accepts
- `out_wid`, `out_PC`, `out_tmask`, `out_instr`, `out_uuid`  out  same widths as inputs  head entry of the granted warp
- `ibuf_pop`  out  NUM_WARPS  one-hot pulse; bit w set in a cycle where an entry of warp w is dequeued
- `ibuf_empty`  out  NUM_WARPS  per-warp queue empty status

## Operation
- Each warp has a circular queue with read pointer, write pointer and count. Count is clog2(IBUF_SIZE+1) bits wide. Pointers wrap modulo IBUF_SIZE.
- Push: `in_fire = in_valid && in_ready`, where `in_ready = ~full[in_wid]`.
  - `in_ready` has no combinational dependence on `in_valid` or `out_ready`.
  - A full queue refuses a push even if the same warp pops in that cycle. There is no bypass.
- Arbitration:
  - The request vector is `~ibuf_empty`. A round-robin priority pointer starts at warp 0.
  - After `out_fire`, priority moves to grant+1 (mod NUM_WARPS).
  - While `out_valid && !out_ready`, the grant and the output data are held stable. A newly non-empty warp cannot steal the grant.
- Output:
  - `out_valid = |~ibuf_empty`.
  - `out_*` fields come from the granted queue's head.
  - `out_wid` equals the grant index, which always equals the stored wid.
- Pop: `out_fire = out_valid && out_ready`. The granted queue's read pointer advances, and `ibuf_pop = out_fire ? onehot(grant) : 0`.
- Simultaneous push and pop on the same warp: the count is unchanged and both pointers advance.
- Simultaneous push to warp a and pop from warp b: the two updates are independent.
- Ordering: entries are FIFO within a warp. There is no ordering guarantee across warps.
- Reset, also when asserted mid-operation:
  - All pointers and counts clear, and the priority pointer returns to 0.
  - `ibuf_empty` = all ones. `out_valid`, `ibuf_pop` = 0. `in_ready` = 1.
  - Queued entries are discarded. Fetch's pending counters are reset by the same reset.

## Timing
- Push-to-visible latency is 1 cycle: an entry written at edge N can present `out_valid` in cycle N+1.
- Throughput is 1 push and 1 pop per cycle, sustained.
- `out_*` and `ibuf_pop` are combinational from registered state plus `out_ready` (for `ibuf_pop` only).
- `in_ready` is a function of registered count and `in_wid` only.

## Structure
- `VX_gpu_pkg`: add a fetch-data struct typedef (wid, PC, tmask, instr, uuid). The ports may be grouped with it.
- `NW_WIDTH` and the IBUF count width are derived locally with clog2.
- Sub-module `vx_ibuf_queue`: a single-warp circular FIFO with count, full, empty and LUTRAM storage, instantiated with a generate loop per warp.
- Arbitration uses the existing round-robin arbiter with a lock-on-stall input.

## Test plan
- Reset mid-traffic: push 3 entries to warp 1, assert reset asynchronously mid-cycle. Outputs go to reset values immediately. After release, `out_valid`=0 and `ibuf_empty`=4'b1111.
- Per-warp full: push 4 entries to warp 2 with out_ready=0. `in_ready`=0 for in_wid=2 and 1 for in_wid=0. A push to warp 0 is accepted the same cycle.
- Ordering: push PCs 0x100, 0x102, 0x104 to warp 3, then drain. Outputs appear in that order with `ibuf_pop`=4'b1000 each cycle.
- Round-robin: warps 0–3 each hold 2 entries, out_ready=1. Grant sequence is 0,1,2,3,0,1,2,3. Each `ibuf_pop` is one-hot.
- Stall stability: with warp 1 granted, set out_ready=0 for 5 cycles while pushing to warp 0. `out_wid`, `out_PC` and the other fields stay constant and `ibuf_pop`=0.
- Full with simultaneous pop: warp 0 holds 4 entries, push to warp 0 and pop warp 0 in the same cycle. The push is refused, count becomes 3, and `in_ready` returns to 1 the next cycle.
